sa_share_arbiter: RTL and testbench
===================================

# sa_share_arbiter

Time-multiplexes one SA_wrapper systolic array among N_CH independent attention cores, such as one core per head. It sits between the cores' SA request ports and a single SA_wrapper instance. It latches single-cycle start requests and arbitrates between them in round-robin or fixed-priority mode. For the granted channel it issues the clear/start sequence to the array, steers operands and returns the valid pulse, the PE-shift and the result; a watchdog aborts hung jobs.

## Interface
- D_W, 16, element width
- SA_R, 16, array rows
- SA_C, 16, array columns
- N_CH, 4, number of requesting channels (2..16)
- TIMEOUT, 4096, max cycles in RUN before abort (≥2)
- I_CLK  in  1  clock
- I_ASYN_RSTN  in  1  asynchronous reset, active-low
- I_SYNC_RSTN  in  1  synchronous reset, active-low; same effect as async reset
- I_RR_EN  in  1  1 = round-robin, 0 = fixed priority (channel 0 highest)
- I_CH_START  in  N_CH  per-channel single-cycle job request (attention O_SA_START)
- I_CH_MAT_1  in  N_CH×SA_R×SA_C×D_W  per-channel left operand
- I_CH_MAT_2  in  N_CH×SA_R×SA_C×D_W  per-channel weight operand
- O_CH_VLD  out  N_CH  per-channel one-cycle job-done pulse
- O_CH_PE_SHIFT  out  N_CH  per-channel PE-shift (granted channel only)
- O_CH_RESULT  out  SA_R×SA_C×D_W  result, broadcast to all channels
- O_SA_START  out  1  start to SA_wrapper I_START_FLAG
- O_SA_CLEARN  out  1  to SA_wrapper I_SYNC_RSTN
- O_MAT_1, O_MAT_2  out  SA_R×SA_C×D_W  operands to SA_wrapper
- I_SA_VLD  in  1  SA_wrapper O_OUT_VLD
- I_SA_PE_SHIFT  in  1  SA_wrapper O_PE_SHIFT
- I_SA_RESULT  in  SA_R×SA_C×D_W  SA_wrapper O_OUT
- O_GRANT  out  $clog2(N_CH)  current/last granted channel
- O_BUSY  out  1  state ≠ IDLE
- O_TIMEOUT  out  1  one-cycle pulse on watchdog abort
- O_REQ_OVF  out  N_CH  sticky, set on a start pulse to an already-pending channel

## Operation
- pending[N_CH]: a bit is set by an I_CH_START pulse and cleared when that channel's job completes or aborts. If set and clear coincide, set wins. A start pulse to an already-pending channel is dropped and sets O_REQ_OVF[ch].
- FSM IDLE → CLEAR → LAUNCH → RUN → IDLE.
- IDLE: if pending≠0, register the winner into O_GRANT → CLEAR.
  - Fixed priority: lowest pending index wins.
  - Round-robin: search starts at O_GRANT+1 mod N_CH.
  - I_RR_EN is sampled at each arbitration.
- CLEAR: O_SA_CLEARN=0 for one cycle → LAUNCH.
- LAUNCH: O_SA_START=1 for one cycle → RUN; the watchdog counter is cleared.
- RUN: the counter increments each cycle.
  - I_SA_VLD=1: O_CH_VLD[grant]=1 in the same cycle (combinational), pending[grant] is cleared → IDLE. Only the first VLD cycle is consumed.
  - Counter reaches TIMEOUT-1 without VLD: O_TIMEOUT=1, pending[grant] is cleared, no O_CH_VLD → IDLE. The next job's CLEAR scrubs the array.
- Operand steering: O_MAT_1/O_MAT_2 = I_CH_MAT_x[O_GRANT] in all states.
- Channels hold their operands stable from their start pulse until their O_CH_VLD or an abort.
- O_CH_PE_SHIFT[g] = I_SA_PE_SHIFT while in RUN and g==O_GRANT; otherwise 0.
- O_CH_RESULT = I_SA_RESULT (pass-through). It is valid only in the cycle O_CH_VLD is high.
- Either reset clears: state, pending, O_GRANT (to N_CH-1, so the first RR search starts at channel 0), the counter and O_REQ_OVF. A reset mid-job abandons the job silently.

## Timing
- Reset values:
  - O_SA_START=0, O_SA_CLEARN=1, O_CH_VLD=0, O_CH_PE_SHIFT=0, O_TIMEOUT=0, O_BUSY=0, O_REQ_OVF=0.
  - O_GRANT=N_CH-1.
  - O_MAT_x follow channel N_CH-1.
- Latency from a start pulse in cycle t with the block idle:
  - pending is visible at t+1;
  - IDLE arbitrates at t+1 (→ CLEAR at t+2);
  - CLEARN=0 at t+2, START=1 at t+3.
- O_CH_VLD occurs in the same cycle as I_SA_VLD. The next grant's CLEAR comes 2 cycles after VLD (one cycle in IDLE between jobs).
- Back-to-back: a granted channel may re-request in or after its O_CH_VLD cycle; this is not an overflow.
- I_SA_VLD seen outside RUN is ignored.
- O_BUSY=1 from CLEAR through the VLD/abort cycle inclusive.

## Test plan
- Single job, N_CH=4, channel 2 started at t: CLEARN low at t+2, START at t+3. SA returns VLD k cycles later with Q·Kᵀ of the ramp matrices (rows 0x000..0xF00) → O_CH_VLD=4'b0100 for one cycle, result matches the golden value, O_GRANT=2.
- Simultaneous starts on channels 0,1,3 with RR: grants 0,1,3. Fixed priority with channel 0 re-requesting on each VLD: channel 0 served every time, channel 1 starves.
- RR wrap: O_GRANT=3, pending={0,3} → next grant is 0, then 3.
- Overflow: second start on pending channel 1 → O_REQ_OVF=4'b0010 (sticky); only one VLD is delivered to channel 1.
- Timeout: TIMEOUT=16, SA never asserts VLD → O_TIMEOUT at LAUNCH+16, no O_CH_VLD, pending bit cleared, next pending channel granted.
- Reset mid-RUN (async and sync): all outputs return to reset values immediately (async) or at the next edge (sync). A later VLD is ignored and no O_CH_VLD appears.

Source files
------------

// File: rtl/sa_share_arbiter_if.sv
// sa_share_arbiter_if: channel-side and SA_wrapper-side bundle
// for the shared systolic-array arbiter.
interface sa_share_arbiter_if #(
  parameter int D_W  = 16,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  parameter int N_CH = 4
);
  localparam int M_W = SA_R * SA_C * D_W;
  localparam int GW  = $clog2(N_CH);

  logic                      I_RR_EN;
  logic [N_CH-1:0]           I_CH_START;
  logic [N_CH-1:0][M_W-1:0]  I_CH_MAT_1;
  logic [N_CH-1:0][M_W-1:0]  I_CH_MAT_2;
  logic [N_CH-1:0]           O_CH_VLD;
  logic [N_CH-1:0]           O_CH_PE_SHIFT;
  logic [M_W-1:0]            O_CH_RESULT;
  logic                      O_SA_START;
  logic                      O_SA_CLEARN;
  logic [M_W-1:0]            O_MAT_1;
  logic [M_W-1:0]            O_MAT_2;
  logic                      I_SA_VLD;
  logic                      I_SA_PE_SHIFT;
  logic [M_W-1:0]            I_SA_RESULT;
  logic [GW-1:0]             O_GRANT;
  logic                      O_BUSY;
  logic                      O_TIMEOUT;
  logic [N_CH-1:0]           O_REQ_OVF;

  modport slave (
    input  I_RR_EN, I_CH_START,
    input  I_CH_MAT_1, I_CH_MAT_2,
    input  I_SA_VLD, I_SA_PE_SHIFT,
    input  I_SA_RESULT,
    output O_CH_VLD, O_CH_PE_SHIFT,
    output O_CH_RESULT,
    output O_SA_START, O_SA_CLEARN,
    output O_MAT_1, O_MAT_2,
    output O_GRANT, O_BUSY,
    output O_TIMEOUT, O_REQ_OVF
  );

  modport master (
    output I_RR_EN, I_CH_START,
    output I_CH_MAT_1, I_CH_MAT_2,
    output I_SA_VLD, I_SA_PE_SHIFT,
    output I_SA_RESULT,
    input  O_CH_VLD, O_CH_PE_SHIFT,
    input  O_CH_RESULT,
    input  O_SA_START, O_SA_CLEARN,
    input  O_MAT_1, O_MAT_2,
    input  O_GRANT, O_BUSY,
    input  O_TIMEOUT, O_REQ_OVF
  );
endinterface

// File: rtl/sa_share_arbiter.sv
// sa_share_arbiter: time-multiplexes one SA_wrapper among N_CH
// attention cores with RR/fixed arbitration and a run watchdog.
module sa_share_arbiter #(
  parameter int D_W     = 16,
  parameter int SA_R    = 16,
  parameter int SA_C    = 16,
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic I_CLK,
  input  logic I_ASYN_RSTN,
  input  logic I_SYNC_RSTN,
  sa_share_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_CH);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    RUN
  } state_t;

  state_t state, state_n;

  logic [N_CH-1:0] pending, pending_n;
  logic [N_CH-1:0] ovf, ovf_n;
  logic [N_CH-1:0] start;
  logic [N_CH-1:0] done_mask;
  logic [N_CH-1:0] vld_mask;
  logic [N_CH-1:0] pe_mask;
  logic [GW-1:0]   grant, grant_n;
  logic [GW-1:0]   win;
  logic            found;
  logic [CW-1:0]   cnt, cnt_n;
  logic            run, vld, tmo, done;
  logic            clearn, launch;

  assign start = bus.I_CH_START;
  assign run   = state == RUN;
  assign vld   = run & bus.I_SA_VLD;
  assign tmo   = run & ~bus.I_SA_VLD
               & (cnt == CW'(TIMEOUT - 1));
  assign done  = vld | tmo;

  // RR search begins just past the last grant
  always_comb begin : arb
    int idx;
    idx   = 0;
    win   = grant;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = bus.I_RR_EN ? int'(grant) + 1 + i : i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && pending[idx[GW-1:0]]) begin
        win   = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    done_mask        = '0;
    vld_mask         = '0;
    pe_mask          = '0;
    done_mask[grant] = done;
    vld_mask[grant]  = vld;
    pe_mask[grant]   = run & bus.I_SA_PE_SHIFT;
  end

  // a new start wins over the completion clear
  assign pending_n = (pending & ~done_mask) | start;
  assign ovf_n     = ovf
                   | (start & pending & ~done_mask);

  always_comb begin
    state_n = state;
    grant_n = grant;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = win;
          state_n = CLEAR;
        end
      end
      CLEAR: state_n = LAUNCH;
      LAUNCH: begin
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        cnt_n = cnt + 1'b1;
        if (done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state   <= IDLE;
      pending <= '0;
      ovf     <= '0;
      grant   <= GW'(N_CH - 1);
      cnt     <= '0;
    end else if (!I_SYNC_RSTN) begin
      state   <= IDLE;
      pending <= '0;
      ovf     <= '0;
      grant   <= GW'(N_CH - 1);
      cnt     <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      ovf     <= ovf_n;
      grant   <= grant_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    clearn = 1'b1;
    launch = 1'b0;
    unique case (1'b1)
      state == CLEAR:  clearn = 1'b0;
      state == LAUNCH: launch = 1'b1;
      default: ;
    endcase
  end

  assign bus.O_SA_CLEARN   = clearn;
  assign bus.O_SA_START    = launch;
  assign bus.O_CH_VLD      = vld_mask;
  assign bus.O_CH_PE_SHIFT = pe_mask;
  assign bus.O_CH_RESULT   = bus.I_SA_RESULT;
  assign bus.O_MAT_1       = bus.I_CH_MAT_1[grant];
  assign bus.O_MAT_2       = bus.I_CH_MAT_2[grant];
  assign bus.O_GRANT       = grant;
  assign bus.O_BUSY        = state != IDLE;
  assign bus.O_TIMEOUT     = tmo;
  assign bus.O_REQ_OVF     = ovf;
endmodule

// File: tb/tb_sa_share_arbiter.sv
// tb_sa_share_arbiter: directed bench with a cycle model of the
// arbiter and a small SA_wrapper emulator computing Q*K^T.
module tb_sa_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int TO = 16;
  localparam int MW = R * C * DW;

  logic clk = 1'b0;
  logic arst_n;
  logic srst_n;
  always #5 clk = ~clk;

  sa_share_arbiter_if #(
    .D_W(DW), .SA_R(R), .SA_C(C), .N_CH(N)
  ) bus ();

  sa_share_arbiter #(
    .D_W(DW), .SA_R(R), .SA_C(C),
    .N_CH(N), .TIMEOUT(TO)
  ) dut (
    .I_CLK(clk),
    .I_ASYN_RSTN(arst_n),
    .I_SYNC_RSTN(srst_n),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // model: age -1 idle, 0 clear cycle, 1 start cycle, >=2 running
  logic [N-1:0] pend_m;
  logic [N-1:0] ovf_m;
  int g_m;
  int age;

  int sa_lat = 3;
  int sa_cnt = 0;
  logic [MW-1:0] sa_res;

  int clr_cyc, st_cyc, vld_cyc, tmo_cyc;
  logic [N-1:0] vld_mask;
  logic [MW-1:0] res;
  int vcnt[N];
  int gq[$];

  function automatic logic [MW-1:0] qkt(
    logic [MW-1:0] a, logic [MW-1:0] b);
    logic [MW-1:0] r;
    logic [DW-1:0] s;
    r = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) begin
        s = '0;
        for (int k = 0; k < C; k++)
          s = s + a[(i*C+k)*DW +: DW] * b[(j*C+k)*DW +: DW];
        r[(i*C+j)*DW +: DW] = s;
      end
    return r;
  endfunction

  function automatic logic [N-1:0] oh(int i, bit en);
    logic [N-1:0] m;
    m = '0;
    m[i] = en;
    return m;
  endfunction

  function automatic logic [63:0] gsig();
    logic [63:0] s;
    s = 0;
    foreach (gq[i]) s = (s << 4) | 64'(gq[i] + 1);
    return s;
  endfunction

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    pend_m = '0;
    ovf_m  = '0;
    g_m    = N - 1;
    age    = -1;
  endtask

  task automatic compare();
    bit run, v, t;
    run = age >= 2;
    v = run && bus.I_SA_VLD;
    t = run && !bus.I_SA_VLD && (age - 2 == TO - 1);
    chk("busy", bus.O_BUSY, age >= 0);
    chk("clearn", bus.O_SA_CLEARN, age != 0);
    chk("start", bus.O_SA_START, age == 1);
    chk("timeout", bus.O_TIMEOUT, t);
    chk("ch_vld", bus.O_CH_VLD, oh(g_m, v));
    chk("pe_shift", bus.O_CH_PE_SHIFT,
        oh(g_m, run && bus.I_SA_PE_SHIFT));
    chk("grant", bus.O_GRANT, g_m);
    chk("req_ovf", bus.O_REQ_OVF, ovf_m);
    chk("mat1", bus.O_MAT_1, bus.I_CH_MAT_1[g_m]);
    chk("mat2", bus.O_MAT_2, bus.I_CH_MAT_2[g_m]);
    if (v)
      chk("result", bus.O_CH_RESULT,
          qkt(bus.I_CH_MAT_1[g_m], bus.I_CH_MAT_2[g_m]));
  endtask

  task automatic model_step();
    bit run, done;
    int w, c;
    if (!arst_n || !srst_n) begin
      model_reset();
      return;
    end
    run  = age >= 2;
    done = run && (bus.I_SA_VLD || (age - 2 == TO - 1));
    if (age < 0) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        c = bus.I_RR_EN ? (g_m + 1 + i) % N : i;
        if (w < 0 && pend_m[c]) w = c;
      end
      if (w >= 0) begin
        g_m = w;
        age = 0;
      end
    end else if (done) begin
      pend_m[g_m] = 1'b0;
      age = -1;
    end else begin
      age++;
    end
    for (int i = 0; i < N; i++)
      if (bus.I_CH_START[i]) begin
        if (pend_m[i]) ovf_m[i] = 1'b1;
        pend_m[i] = 1'b1;
      end
  endtask

  task automatic observe();
    if (!bus.O_SA_CLEARN) clr_cyc = cyc;
    if (bus.O_SA_START) begin
      st_cyc = cyc;
      gq.push_back(int'(bus.O_GRANT));
      sa_res = qkt(bus.O_MAT_1, bus.O_MAT_2);
      sa_cnt = sa_lat;
    end
    if (bus.O_TIMEOUT) tmo_cyc = cyc;
    if (bus.O_CH_VLD != 0) begin
      vld_cyc  = cyc;
      vld_mask = bus.O_CH_VLD;
      res      = bus.O_CH_RESULT;
      for (int i = 0; i < N; i++)
        if (bus.O_CH_VLD[i]) vcnt[i]++;
    end
  endtask

  task automatic sa_drive();
    bus.I_SA_VLD      = 1'b0;
    bus.I_SA_PE_SHIFT = 1'b0;
    bus.I_SA_RESULT   = 32'hDEADBEEF;
    if (sa_cnt > 0) begin
      sa_cnt--;
      if (sa_cnt == 0) begin
        bus.I_SA_VLD    = 1'b1;
        bus.I_SA_RESULT = sa_res;
      end else begin
        bus.I_SA_PE_SHIFT = sa_cnt[0];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    observe();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    bus.I_CH_START = '0;
    sa_drive();
  endtask

  task automatic wait_idle(string nm, int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (age < 0 && pend_m == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: still busy after %0d cycles",
               nm, budget);
    end
  endtask

  task automatic wait_run(string nm);
    for (int i = 0; i < 10 && age < 3; i++) tick();
    chk(nm, age >= 3, 1);
  endtask

  int t0, d, v0, v1, v2, v3, rq;

  initial begin
    model_reset();
    arst_n = 1'b0;
    srst_n = 1'b1;
    bus.I_RR_EN       = 1'b1;
    bus.I_CH_START    = '0;
    bus.I_SA_VLD      = 1'b0;
    bus.I_SA_PE_SHIFT = 1'b0;
    bus.I_SA_RESULT   = '0;
    for (int c = 0; c < N; c++) begin
      bus.I_CH_MAT_1[c] = {4{8'(c + 1)}};
      bus.I_CH_MAT_2[c] = 32'h01020304 ^ 32'(c);
      vcnt[c] = 0;
    end
    bus.I_CH_MAT_1[2] = 32'h04030201;
    bus.I_CH_MAT_2[2] = 32'h08070605;
    tick();
    tick();
    arst_n = 1'b1;
    chk("rst_grant", bus.O_GRANT, 3);
    chk("rst_clearn", bus.O_SA_CLEARN, 1);
    chk("rst_busy", bus.O_BUSY, 0);
    tick();

    // RR from reset: simultaneous 0,1,3
    gq.delete();
    bus.I_CH_START = 4'b1011;
    tick();
    wait_idle("rr_multi", 200);
    chk("rr_multi_grants", gsig(), 64'h124);

    // RR wrap from grant 3
    gq.delete();
    bus.I_CH_START = 4'b1001;
    tick();
    wait_idle("rr_wrap", 200);
    chk("rr_wrap_grants", gsig(), 64'h14);

    // single job on channel 2, latencies and golden result
    t0 = cyc;
    bus.I_CH_START = 4'b0100;
    tick();
    wait_idle("single", 60);
    chk("single_clearn_lat", 64'(clr_cyc - t0), 2);
    chk("single_start_lat", 64'(st_cyc - t0), 3);
    chk("single_vld_lat", 64'(vld_cyc - st_cyc), 3);
    chk("single_vld_mask", vld_mask, 4'b0100);
    chk("single_result", res, 32'h35271711);
    chk("single_grant", bus.O_GRANT, 2);

    // fixed priority: channel 0 re-requests on its VLD
    bus.I_RR_EN = 1'b0;
    gq.delete();
    rq = 0;
    bus.I_CH_START = 4'b0011;
    tick();
    for (int i = 0; i < 300; i++) begin
      if (age < 0 && pend_m == 0) break;
      if (bus.I_SA_VLD && age >= 2 && g_m == 0 && rq < 3) begin
        bus.I_CH_START[0] = 1'b1;
        rq++;
      end
      tick();
    end
    chk("fixed_grants", gsig(), 64'h11112);
    chk("fixed_no_ovf", bus.O_REQ_OVF, 0);

    // overflow on channel 1
    bus.I_RR_EN = 1'b1;
    v1 = vcnt[1];
    bus.I_CH_START = 4'b0010;
    tick();
    bus.I_CH_START = 4'b0010;
    tick();
    wait_idle("ovf", 60);
    chk("ovf_flag", bus.O_REQ_OVF, 4'b0010);
    chk("ovf_one_vld", 64'(vcnt[1] - v1), 1);
    bus.I_CH_START = 4'b1000;
    tick();
    wait_idle("ovf_sticky", 60);
    chk("ovf_sticky", bus.O_REQ_OVF, 4'b0010);

    // watchdog: channel 2 hangs, channel 3 then served
    sa_lat = 0;
    gq.delete();
    tmo_cyc = -1;
    v2 = vcnt[2];
    v3 = vcnt[3];
    bus.I_CH_START = 4'b1100;
    tick();
    for (int i = 0; i < 60 && tmo_cyc < 0; i++) tick();
    d = tmo_cyc - st_cyc;
    chk("tmo_lat", 64'(d), 16);
    sa_lat = 2;
    wait_idle("tmo", 100);
    chk("tmo_grants", gsig(), 64'h34);
    chk("tmo_no_vld", 64'(vcnt[2] - v2), 0);
    chk("tmo_next_vld", 64'(vcnt[3] - v3), 1);

    // VLD while idle is ignored
    v0 = vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3];
    bus.I_SA_VLD = 1'b1;
    tick();
    chk("stray_vld",
        64'(vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3] - v0), 0);

    // async reset mid-run
    sa_lat = 6;
    v0 = vcnt[0];
    bus.I_CH_START = 4'b0001;
    tick();
    wait_run("arst_reach_run");
    arst_n = 1'b0;
    #1;
    chk("arst_busy", bus.O_BUSY, 0);
    chk("arst_clearn", bus.O_SA_CLEARN, 1);
    chk("arst_start", bus.O_SA_START, 0);
    chk("arst_grant", bus.O_GRANT, 3);
    chk("arst_ovf", bus.O_REQ_OVF, 0);
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    arst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("arst_no_vld", 64'(vcnt[0] - v0), 0);

    // sync reset mid-run
    v1 = vcnt[1];
    bus.I_CH_START = 4'b0010;
    tick();
    wait_run("srst_reach_run");
    srst_n = 1'b0;
    tick();
    chk("srst_busy", bus.O_BUSY, 0);
    chk("srst_grant", bus.O_GRANT, 3);
    srst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("srst_no_vld", 64'(vcnt[1] - v1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
